// File: rtl/clock_reset_gen_if.sv
// Board-pin / core-facing signal bundle for clock_reset_gen.
// Latency: none, wires only. Backpressure: none, all signals are levels or one-cycle pulses.
// Optional CLKGEN_TICK_COUNT_EN adds the tick_cnt observation bus.
interface clock_reset_gen_if #(
    parameter int DIV_W = 24
);
    // Raw board inputs (asynchronous to clk except div_val)
    logic             rst_btn_n;
    logic             step_btn_n;
    logic             mode_step;
    logic [DIV_W-1:0] div_val;

    // Generated core controls
    logic             clk_en;
    logic             core_rst_n;
    logic [1:0]       btn_db;
`ifdef CLKGEN_TICK_COUNT_EN
    logic [31:0]      tick_cnt;
`endif

    // Generator side
    modport master (
`ifdef CLKGEN_TICK_COUNT_EN
        output tick_cnt,
`endif
        input  rst_btn_n,
        input  step_btn_n,
        input  mode_step,
        input  div_val,
        output clk_en,
        output core_rst_n,
        output btn_db
    );

    // Board / core side
    modport slave (
`ifdef CLKGEN_TICK_COUNT_EN
        input  tick_cnt,
`endif
        output rst_btn_n,
        output step_btn_n,
        output mode_step,
        output div_val,
        input  clk_en,
        input  core_rst_n,
        input  btn_db
    );
endinterface

// File: rtl/clock_reset_gen.sv
// Clock-enable divider, debounced/stretched core reset and single-step generator for the d16 core.
// Latency: clk_en 1 cycle after divider match or debounced step press; core_rst_n 1 cycle after debounced reset press.
// Backpressure: none; the core qualifies its registers with clk_en. Optional macro CLKGEN_TICK_COUNT_EN adds tick_cnt.
module clock_reset_gen #(
    parameter int DIV_W       = 24,
    parameter int SYNC_STAGES = 3,
    parameter int DEB_CYCLES  = 50000,
    parameter int RST_HOLD    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    clock_reset_gen_if.master bus
);

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    // Bit 0 of the debounce pair is the reset button, bit 1 the step button,
    // matching the {step, rst} ordering of btn_db.
    localparam int RST_IDX  = 0;
    localparam int STEP_IDX = 1;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } rst_state_e;

    // ------------------------------------------------------------------
    // Synchronisers: idle level of every input is 1, so reset fills with 1s
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] step_sync_q;
    logic [SYNC_STAGES-1:0] mode_sync_q;

    logic [1:0] btn_sync;
    logic       mode_sync;

    // Shift each raw input through its own flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q  <= '1;
            step_sync_q <= '1;
            mode_sync_q <= '1;
        end else begin
            rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0],  bus.rst_btn_n};
            step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], bus.step_btn_n};
            mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], bus.mode_step};
        end
    end

    assign btn_sync[RST_IDX]  = rst_sync_q[SYNC_STAGES-1];
    assign btn_sync[STEP_IDX] = step_sync_q[SYNC_STAGES-1];
    // The mode switch is a slow level; synchronisation alone is enough.
    assign mode_sync          = mode_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debouncers: level follows the input only after DEB_CYCLES stable cycles
    // ------------------------------------------------------------------
    logic [1:0]            db_q;
    logic [1:0]            db_d;
    logic [1:0][DEB_W-1:0] deb_cnt_q;
    logic [1:0][DEB_W-1:0] deb_cnt_d;

    // Any return to the current level clears the count, so short glitches never land
    always_comb begin
        db_d      = db_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (btn_sync[i] != db_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    db_d[i] = btn_sync[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounced levels and their stability counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= 2'b11;
            deb_cnt_q <= '0;
        end else begin
            db_q      <= db_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Core reset FSM: ASSERT while pressed, HOLD for RST_HOLD cycles, then RUN
    // ------------------------------------------------------------------
    rst_state_e        state_q;
    rst_state_e        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              core_rst_n_q;
    logic              core_rst_n_d;

    // Next-state logic; a press always wins, even on the last HOLD cycle
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        case (state_q)
            ST_RUN: begin
                if (!db_q[RST_IDX]) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (db_q[RST_IDX]) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!db_q[RST_IDX]) begin
                    state_d = ST_ASSERT;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Registering from the next state keeps core_rst_n glitch-free with no extra cycle
    assign core_rst_n_d = (state_d == ST_RUN);

    // State, hold counter and registered core reset; power-on starts in HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HOLD;
            hold_q       <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // ------------------------------------------------------------------
    // clk_en generation: free-running divider or one pulse per step press
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             clk_en_q;
    logic             clk_en_d;
    logic             step_prev_q;
    logic             step_fall;

    // Tracked in both modes so a press made in free-run cannot fire later in step mode
    assign step_fall = step_prev_q & ~db_q[STEP_IDX];

    // Divider is not gated by core reset: the core must see enables while held in reset.
    // A div_val lowered below the current count lets the counter wrap naturally, no pulse.
    always_comb begin
        div_d    = div_q;
        clk_en_d = 1'b0;
        if (mode_sync) begin
            div_d    = '0;
            clk_en_d = step_fall;
        end else if (div_q == bus.div_val) begin
            div_d    = '0;
            clk_en_d = 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Divider count, registered enable and step edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            clk_en_q    <= 1'b0;
            step_prev_q <= 1'b1;
        end else begin
            div_q       <= div_d;
            clk_en_q    <= clk_en_d;
            step_prev_q <= db_q[STEP_IDX];
        end
    end

`ifdef CLKGEN_TICK_COUNT_EN
    // ------------------------------------------------------------------
    // Enabled-edge counter, only meaningful while the core is out of reset
    // ------------------------------------------------------------------
    logic [31:0] tick_cnt_q;
    logic [31:0] tick_cnt_d;

    // Cleared from the next core reset so it reads 0 in the same cycle core_rst_n drops
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (!core_rst_n_d) begin
            tick_cnt_d = '0;
        end else if (clk_en_q && core_rst_n_q) begin
            tick_cnt_d = tick_cnt_q + 32'd1;
        end
    end

    // Tick counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign bus.tick_cnt = tick_cnt_q;
`endif

    assign bus.clk_en     = clk_en_q;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.btn_db     = db_q;

endmodule

// File: tb/tb_clock_reset_gen.sv
// Directed bench for clock_reset_gen with SYNC_STAGES=2, DEB_CYCLES=4, RST_HOLD=3, DIV_W=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Covers power-on stretch, divider, debounce, reset stretch, step mode and async reset.
module tb_clock_reset_gen;

    logic clk;
    logic rst_n;

    clock_reset_gen_if #(.DIV_W(8)) bus ();

    clock_reset_gen #(
        .DIV_W       (8),
        .SYNC_STAGES (2),
        .DEB_CYCLES  (4),
        .RST_HOLD    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic        found;
    logic        db_ok;
    logic        core_ok;
    logic [9:0]  pat10;
    logic [7:0]  pat8;
    logic [4:0]  pat5;
    logic [29:0] pat30;
    logic [29:0] exp30;
    int          npulse;
`ifdef CLKGEN_TICK_COUNT_EN
    logic [31:0] c0;
`endif

    initial begin
        rst_n          = 1'b0;
        bus.rst_btn_n  = 1'b1;
        bus.step_btn_n = 1'b1;
        bus.mode_step  = 1'b0;
        bus.div_val    = 8'd4;
        tick(3);

        // Reset values
        chk("rst_clk_en",     32'(bus.clk_en),     32'd0);
        chk("rst_core_rst_n", 32'(bus.core_rst_n), 32'd0);
        chk("rst_btn_db",     32'(bus.btn_db),     32'd3);

        // Power-on stretch: low for 3 edges after release
        rst_n = 1'b1;
        tick(2);
        chk("por_core_low",  32'(bus.core_rst_n), 32'd0);
        tick(1);
        chk("por_core_high", 32'(bus.core_rst_n), 32'd1);
        chk("por_btn_db",    32'(bus.btn_db),     32'd3);

        // Free-run div_val=4: one pulse every 5 cycles
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1);
            if (bus.clk_en) found = 1'b1;
        end
        chk("div4_found", 32'(found), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            pat10[i] = bus.clk_en;
        end
        chk("div4_pattern", 32'(pat10), 32'h210);

        // Counter is 0 right after a pulse, so div_val=0 takes effect immediately
        bus.div_val = 8'd0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            pat8[i] = bus.clk_en;
        end
        chk("div0_pattern", 32'(pat8), 32'hFF);

        // 3-cycle reset glitch is rejected
        bus.rst_btn_n = 1'b0;
        db_ok   = 1'b1;
        core_ok = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) bus.rst_btn_n = 1'b1;
            tick(1);
            db_ok   = db_ok & bus.btn_db[0];
            core_ok = core_ok & bus.core_rst_n;
        end
        chk("glitch_btn_db0", 32'(db_ok),   32'd1);
        chk("glitch_core",    32'(core_ok), 32'd1);

        // 20-cycle reset press
        bus.rst_btn_n = 1'b0;
        tick(5);
        chk("press_db0_pre",  32'(bus.btn_db[0]),  32'd1);
        tick(1);
        chk("press_db0_fall", 32'(bus.btn_db[0]),  32'd0);
        chk("press_core_pre", 32'(bus.core_rst_n), 32'd1);
        tick(1);
        chk("press_core_low", 32'(bus.core_rst_n), 32'd0);
        tick(13);
        bus.rst_btn_n = 1'b1;
        tick(5);
        chk("rel_db0_pre",    32'(bus.btn_db[0]),  32'd0);
        tick(1);
        chk("rel_db0_rise",   32'(bus.btn_db[0]),  32'd1);
        tick(3);
        chk("rel_core_pre",   32'(bus.core_rst_n), 32'd0);
        tick(1);
        chk("rel_core_high",  32'(bus.core_rst_n), 32'd1);

        // Step mode: divider stops
        bus.mode_step = 1'b1;
        tick(4);
        chk("step_idle_clk_en", 32'(bus.clk_en), 32'd0);

        // Hold step for 30 cycles: exactly one pulse, 1 cycle after btn_db[1] falls
        bus.step_btn_n = 1'b0;
        npulse = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (bus.clk_en) npulse++;
            if (i == 5) chk("step_db1_pre",  32'(bus.btn_db[1]), 32'd1);
            if (i == 6) chk("step_db1_fall", 32'(bus.btn_db[1]), 32'd0);
            if (i == 7) chk("step_pulse_at", 32'(bus.clk_en),    32'd1);
        end
        chk("step_pulse_count", 32'(npulse), 32'd1);

        bus.step_btn_n = 1'b1;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.clk_en) npulse++;
        end
        chk("step_release_count", 32'(npulse), 32'd0);

        bus.step_btn_n = 1'b0;
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (bus.clk_en) npulse++;
        end
        chk("step_second_count", 32'(npulse), 32'd1);
        bus.step_btn_n = 1'b1;
        tick(8);

        // Step -> run with div_val=2: first pulse 3 cycles after sync'd change
        bus.div_val   = 8'd2;
        bus.mode_step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            pat5[i] = bus.clk_en;
        end
        chk("run_first_pulse", 32'(pat5), 32'h10);

        // Step press in free-run leaves the period-3 pattern untouched
        bus.step_btn_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 13) bus.step_btn_n = 1'b1;
            tick(1);
            pat30[i-1] = bus.clk_en;
            exp30[i-1] = ((i % 3) == 0);
        end
        chk("run_step_ignored", 32'(pat30), 32'(exp30));

        // Counter is 0 after the last pulse above
        bus.div_val = 8'd1;

`ifdef CLKGEN_TICK_COUNT_EN
        c0     = bus.tick_cnt;
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.clk_en) npulse++;
            tick(1);
        end
        chk("tick_pulses", 32'(npulse), 32'd10);
        chk("tick_cnt",    bus.tick_cnt, c0 + 32'd10);
        bus.rst_btn_n = 1'b0;
        tick(7);
        chk("tick_core_low", 32'(bus.core_rst_n), 32'd0);
        chk("tick_cleared",  bus.tick_cnt,        32'd0);
        bus.rst_btn_n = 1'b1;
        tick(12);
`endif

        // Async rst_n mid-operation with step button held down
        bus.step_btn_n = 1'b0;
        tick(7);
        chk("pre_async_btn_db", 32'(bus.btn_db), 32'd1);
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            if (bus.clk_en) found = 1'b1;
            else tick(1);
        end
        chk("pre_async_clk_en", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clk_en",     32'(bus.clk_en),     32'd0);
        chk("async_core_rst_n", 32'(bus.core_rst_n), 32'd0);
        chk("async_btn_db",     32'(bus.btn_db),     32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
